key_event_gen: RTL and testbench
================================

// Module: key_event_gen
// PURPOSE
//  Turns the 16-bit debounced keypad vector from the key filter into discrete key events.
//  Each event carries a 4-bit key code and a one-cycle press strobe.
//  Adds release strobes, a held level, auto-repeat after a hold delay, and multi-key rejection.
//  Sits between the key filter and the code-entry register. It replaces the free-running
//  one-hot decode, so downstream logic sees exactly one strobe per press or repeat.
// PARAMETERS
//  DELAY_CYC  25_000_000  cycles from the initial press strobe to the first repeat strobe (500 ms @ 50 MHz)
//  RATE_CYC   5_000_000   cycles between successive repeat strobes (100 ms @ 50 MHz)
//  Both parameters must be >= 2. The timer width is $clog2(max(DELAY_CYC,RATE_CYC))+1.
// PORTS
//  clk          in   1   system clock, 50 MHz
//  RST          in   1   asynchronous reset, active-high
//  key_deb      in   16  debounced key vector, bit i=1 means key i is pressed; synchronous to clk
//  repeat_en    in   1   1 = auto-repeat enabled
//  key_code     out  4   index of the latched key; valid whenever key_valid or key_held is 1
//  key_valid    out  1   one-cycle strobe on press and on each repeat
//  key_release  out  1   one-cycle strobe when the latched key is released or overridden
//  key_held     out  1   level, 1 while a single accepted key is held
//  multi_err    out  1   level, 1 while a multi-key condition is active
// BEHAVIOUR
//  - key_deb is registered once into smp. All FSM decisions use smp. All outputs are registered.
//  - Reset: state=IDLE, timer=0, key_code=0, and all strobes and levels are 0, immediately on RST.
//  - key_code keeps its last value after release. Only RST clears it.
//  - cnt = popcount(smp). States: IDLE, HOLD, REPEAT, MULTI.
//  - IDLE:
//      cnt==0 -> stay in IDLE.
//      cnt==1 -> latch key_code = index of the set bit, pulse key_valid, set key_held,
//                load timer=DELAY_CYC-1, go to HOLD.
//      cnt>=2 -> set multi_err, go to MULTI. No key_valid.
//  - Latency: key_deb becomes a single key at edge N; key_valid is high in cycle N+2.
//  - HOLD and REPEAT apply these checks in priority order:
//      1) smp==0: pulse key_release, clear key_held, go to IDLE.
//      2) smp != latched one-hot: pulse key_release, clear key_held, set multi_err, go to MULTI.
//         This covers an extra key and a different key.
//      3) repeat_en=0: freeze the timer. No strobes.
//      4) timer==0: pulse key_valid, load timer=RATE_CYC-1, go to (or stay in) REPEAT.
//      5) otherwise: decrement the timer.
//  - Repeat timing: repeat strobes occur DELAY_CYC cycles after the press strobe, then every RATE_CYC cycles.
//  - MULTI: multi_err stays 1 while smp != 0. On the first sample with smp==0, clear multi_err
//    and go to IDLE. Keys held through MULTI never generate a press; all keys must be released first.
//  - key_valid and key_release are never both 1 in the same cycle. key_held=0 whenever multi_err=1.
//  - RST during HOLD/REPEAT with a key still held: after RST is released, the key is treated as a new press
//    (key_valid 2 cycles after the first post-reset edge).
// TESTING (bench uses DELAY_CYC=20, RATE_CYC=5)
//  1. RST=1 with key_deb=16'h0040 -> all outputs 0. Release RST -> key_valid for 1 cycle 2 clocks later,
//     key_code=6, key_held=1.
//  2. key_deb=16'h0008 for 10 cycles, then 0 -> exactly 1 key_valid (code 3). key_held=1 for 10 cycles.
//     1 key_release, 2 cycles after the drop.
//  3. key_deb=16'h8000 held 40 cycles, repeat_en=1 -> key_valid at t0, t0+20, t0+25, t0+30, t0+35, code 15.
//     Repeat with repeat_en=0 -> only the t0 strobe.
//  4. key_deb=16'h0011 from IDLE -> multi_err=1, no key_valid. Then 16'h0001 -> still no strobe.
//     Then 0 -> multi_err=0 2 cycles later; a following 16'h0002 -> key_valid with code 1.
//  5. 16'h0004 held 5 cycles, then 16'h0006 -> 1 key_valid (code 2), then key_release and multi_err=1
//     in the same cycle; no repeats afterwards.
//  6. Assert RST for 1 cycle while in REPEAT with 16'h0200 held -> outputs 0 asynchronously.
//     After release -> fresh key_valid (code 9); the next key_valid comes 20 cycles later.

Source files
------------

// File: rtl/key_event_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_event_gen_if : keypad vector in, key event outputs out          |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
interface key_event_gen_if;
  logic [15:0] key_deb;
  logic        repeat_en;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_release;
  logic        key_held;
  logic        multi_err;

  modport master (
    output key_deb, repeat_en,
    input  key_code, key_valid, key_release, key_held, multi_err
  );

  modport slave (
    input  key_deb, repeat_en,
    output key_code, key_valid, key_release, key_held, multi_err
  );
endinterface
`default_nettype wire

// File: rtl/key_event_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_event_gen : debounced keypad vector -> press/repeat/release     |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module key_event_gen #(
  parameter int DELAY_CYC = 25_000_000,
  parameter int RATE_CYC  = 5_000_000
) (
  input  logic           clk,
  input  logic           RST,
  key_event_gen_if.slave kif
);

  localparam int MAX_CYC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int TW      = $clog2(MAX_CYC) + 1;
  localparam logic [TW-1:0] DELAY_LOAD = TW'(DELAY_CYC - 1);
  localparam logic [TW-1:0] RATE_LOAD  = TW'(RATE_CYC - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, MULTI} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   smp_q;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_release_q, key_release_d;
  logic          key_held_q, key_held_d;
  logic          multi_err_q, multi_err_d;

  logic [4:0]    cnt;
  logic [3:0]    idx;
  logic [15:0]   latched_oh;

  always_comb begin
    cnt = 5'd0;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(smp_q[i]);
      if (smp_q[i]) idx = 4'(i);
    end
  end

  assign latched_oh = 16'h0001 << key_code_q;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    key_held_d    = key_held_q;
    multi_err_d   = multi_err_q;
    unique case (state_q)
      IDLE: begin
        if (cnt == 5'd1) begin
          key_code_d  = idx;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          timer_d     = DELAY_LOAD;
          state_d     = HOLD;
        end else if (cnt != 5'd0) begin
          multi_err_d = 1'b1;
          state_d     = MULTI;
        end
      end
      HOLD, REPEAT: begin
        if (smp_q == 16'h0000) begin
          key_release_d = 1'b1;
          key_held_d    = 1'b0;
          state_d       = IDLE;
        end else if (smp_q != latched_oh) begin
          // an added key or a swap to a different key both count as multi-key
          key_release_d = 1'b1;
          key_held_d    = 1'b0;
          multi_err_d   = 1'b1;
          state_d       = MULTI;
        end else if (!kif.repeat_en) begin
          timer_d = timer_q;
        end else if (timer_q == '0) begin
          key_valid_d = 1'b1;
          timer_d     = RATE_LOAD;
          state_d     = REPEAT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      MULTI: begin
        if (smp_q == 16'h0000) begin
          multi_err_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      smp_q         <= 16'h0000;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_held_q    <= 1'b0;
      multi_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      smp_q         <= kif.key_deb;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      key_held_q    <= key_held_d;
      multi_err_q   <= multi_err_d;
    end
  end

  assign kif.key_code    = key_code_q;
  assign kif.key_valid   = key_valid_q;
  assign kif.key_release = key_release_q;
  assign kif.key_held    = key_held_q;
  assign kif.multi_err   = multi_err_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_key_event_gen : directed bench for key_event_gen (20/5 cycles)   |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_key_event_gen;

  logic clk;
  logic RST;
  key_event_gen_if kif();

  key_event_gen #(.DELAY_CYC(20), .RATE_CYC(5)) dut (
    .clk (clk),
    .RST (RST),
    .kif (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int base  = 0;
  int vcnt, rcnt, hcnt, ovl, rt, mt;
  int vt [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr();
    base = cyc;
    vcnt = 0; rcnt = 0; hcnt = 0; ovl = 0; rt = -1; mt = -1;
    for (int i = 0; i < 16; i++) vt[i] = -1;
  endtask

  // step n cycles, logging strobe times relative to the last clr()
  task automatic run(input int n);
    int rel;
    for (int i = 0; i < n; i++) begin
      tick();
      rel = cyc - base;
      if (kif.key_valid) begin
        if (vcnt < 16) vt[vcnt] = rel;
        vcnt++;
      end
      if (kif.key_release) begin
        if (rcnt == 0) rt = rel;
        rcnt++;
      end
      if (kif.key_held) hcnt++;
      if (kif.multi_err && mt < 0) mt = rel;
      if (kif.key_valid && kif.key_release) ovl++;
      if (kif.key_held && kif.multi_err) ovl++;
    end
  endtask

  initial begin
    RST = 1'b1;
    kif.key_deb   = 16'h0040;
    kif.repeat_en = 1'b1;
    tick(); tick();

    // 1: reset values, then first press after reset
    chk("rst_code",    32'(kif.key_code), 0);
    chk("rst_valid",   32'(kif.key_valid), 0);
    chk("rst_release", 32'(kif.key_release), 0);
    chk("rst_held",    32'(kif.key_held), 0);
    chk("rst_merr",    32'(kif.multi_err), 0);
    RST = 1'b0;
    tick();
    chk("t1_valid_early", 32'(kif.key_valid), 0);
    tick();
    chk("t1_valid", 32'(kif.key_valid), 1);
    chk("t1_code",  32'(kif.key_code), 6);
    chk("t1_held",  32'(kif.key_held), 1);
    tick();
    chk("t1_valid_1cyc", 32'(kif.key_valid), 0);
    kif.key_deb = 16'h0000;
    tick(); tick();
    chk("t1_release", 32'(kif.key_release), 1);
    chk("t1_held_off", 32'(kif.key_held), 0);
    tick(); tick();

    // 2: short press of key 3
    kif.key_deb = 16'h0008;
    clr();
    run(10);
    kif.key_deb = 16'h0000;
    run(6);
    chk("t2_vcnt", vcnt, 1);
    chk("t2_vtime", vt[0], 2);
    chk("t2_code", 32'(kif.key_code), 3);
    chk("t2_held_cycles", hcnt, 10);
    chk("t2_rcnt", rcnt, 1);
    chk("t2_rtime", rt, 12);
    chk("t2_overlap", ovl, 0);

    // 3: long hold of key 15 with auto-repeat
    kif.key_deb = 16'h8000;
    clr();
    run(40);
    kif.key_deb = 16'h0000;
    run(6);
    chk("t3_vcnt", vcnt, 5);
    chk("t3_v0", vt[0], 2);
    chk("t3_v1", vt[1], 22);
    chk("t3_v2", vt[2], 27);
    chk("t3_v3", vt[3], 32);
    chk("t3_v4", vt[4], 37);
    chk("t3_code", 32'(kif.key_code), 15);
    chk("t3_rcnt", rcnt, 1);
    chk("t3_overlap", ovl, 0);

    // 3b: same hold with repeat disabled
    kif.repeat_en = 1'b0;
    kif.key_deb = 16'h8000;
    clr();
    run(40);
    kif.key_deb = 16'h0000;
    run(6);
    chk("t3b_vcnt", vcnt, 1);
    chk("t3b_v0", vt[0], 2);
    kif.repeat_en = 1'b1;

    // 4: multi-key from idle, keys held through MULTI never press
    kif.key_deb = 16'h0011;
    clr();
    run(4);
    chk("t4_merr", 32'(kif.multi_err), 1);
    chk("t4_mtime", mt, 2);
    kif.key_deb = 16'h0001;
    run(25);
    chk("t4_vcnt", vcnt, 0);
    chk("t4_merr_hold", 32'(kif.multi_err), 1);
    chk("t4_overlap", ovl, 0);
    kif.key_deb = 16'h0000;
    tick();
    chk("t4_merr_still", 32'(kif.multi_err), 1);
    tick();
    chk("t4_merr_clear", 32'(kif.multi_err), 0);
    kif.key_deb = 16'h0002;
    tick(); tick();
    chk("t4_valid", 32'(kif.key_valid), 1);
    chk("t4_code", 32'(kif.key_code), 1);
    kif.key_deb = 16'h0000;
    tick(); tick(); tick(); tick();

    // 5: second key joins a held key
    kif.key_deb = 16'h0004;
    clr();
    run(5);
    kif.key_deb = 16'h0006;
    run(35);
    chk("t5_vcnt", vcnt, 1);
    chk("t5_v0", vt[0], 2);
    chk("t5_code", 32'(kif.key_code), 2);
    chk("t5_rtime", rt, 7);
    chk("t5_mtime", mt, 7);
    chk("t5_rcnt", rcnt, 1);
    chk("t5_overlap", ovl, 0);
    kif.key_deb = 16'h0000;
    tick(); tick(); tick();
    chk("t5_merr_clear", 32'(kif.multi_err), 0);

    // 6: async reset while repeating key 9
    kif.key_deb = 16'h0200;
    clr();
    run(25);
    chk("t6_pre_vcnt", vcnt, 2);
    #2 RST = 1'b1;
    #1;
    chk("t6_async_code",  32'(kif.key_code), 0);
    chk("t6_async_valid", 32'(kif.key_valid), 0);
    chk("t6_async_held",  32'(kif.key_held), 0);
    chk("t6_async_merr",  32'(kif.multi_err), 0);
    @(posedge clk);
    #1 RST = 1'b0;
    clr();
    run(24);
    chk("t6_vcnt", vcnt, 2);
    chk("t6_v0", vt[0], 2);
    chk("t6_v1", vt[1], 22);
    chk("t6_code", 32'(kif.key_code), 9);
    kif.key_deb = 16'h0000;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
